// File: rtl/multicycle_stage_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_stage_sequencer
//
// Stage sequencer for the multi-cycle processor. It steps an instruction through
// stages 1..NUM_STAGES and drives the current stage number plus one-hot stage
// enables to the control signal generator.
//
// The fetch stage always waits for MEM_MFC. The memory stage waits for MEM_MFC
// only when the instruction makes a memory access. A wait that lasts
// MFC_TIMEOUT Run cycles, or a MEM_ERROR during a wait, latches a sticky fault.
// Only Reset clears the fault. The block also counts retired instructions and
// the Run cycles spent outside the fault state.
//
// Optional feature macro: STAGE_SINGLE_STEP_EN
//   When this macro is defined, the block gains a Step input. A stage advances
//   only on a Run cycle in which a rising edge of Step is seen. In a wait stage
//   the MFC must also have been seen since the stage was entered.
//
// Ports
//   Clock        in   1           system clock, rising edge
//   Reset        in   1           synchronous, active-high reset
//   Run          in   1           1 = sequence, 0 = freeze all state
//   Step         in   1           single-step request (STAGE_SINGLE_STEP_EN only)
//   Mem_Request  in   1           instruction accesses memory in MEM_STAGE
//   MEM_MFC      in   1           memory function complete
//   MEM_ERROR    in   1           memory reports an unassigned address
//   Stage        out  STAGE_W     0 = idle/fault, 1..NUM_STAGES = active stage
//   Stage_OneHot out  NUM_STAGES  bit (Stage-1) set while a stage is active
//   Mem_Wait     out  1           current stage is held waiting for MEM_MFC
//   Instr_Done   out  1           1-cycle pulse after leaving stage NUM_STAGES
//   Fault        out  1           sticky fault flag
//   Fault_Code   out  2           00 none, 01 MEM_ERROR, 10 MFC timeout
//   Instr_Count  out  32          retired instructions, wrapping
//   Cycle_Count  out  32          Run cycles outside the fault state, wrapping
// -----------------------------------------------------------------------------
module multicycle_stage_sequencer #(
   parameter int NUM_STAGES  = 5,
   parameter int FETCH_STAGE = 1,
   parameter int MEM_STAGE   = 4,
   parameter int MFC_TIMEOUT = 15,
   parameter int STAGE_W     = 4
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Run,
`ifdef STAGE_SINGLE_STEP_EN
   input  logic                  Step,
`endif
   input  logic                  Mem_Request,
   input  logic                  MEM_MFC,
   input  logic                  MEM_ERROR,
   output logic [STAGE_W-1:0]    Stage,
   output logic [NUM_STAGES-1:0] Stage_OneHot,
   output logic                  Mem_Wait,
   output logic                  Instr_Done,
   output logic                  Fault,
   output logic [1:0]            Fault_Code,
   output logic [31:0]           Instr_Count,
   output logic [31:0]           Cycle_Count
);

   localparam logic [STAGE_W-1:0] ZERO_C    = {STAGE_W{1'b0}};
   localparam logic [STAGE_W-1:0] FIRST_C   = STAGE_W'(1);
   localparam logic [STAGE_W-1:0] LAST_C    = STAGE_W'(NUM_STAGES);
   localparam logic [STAGE_W-1:0] FETCH_C   = STAGE_W'(FETCH_STAGE);
   localparam logic [STAGE_W-1:0] MEM_C     = STAGE_W'(MEM_STAGE);
   localparam logic [7:0]         TIMEOUT_C = 8'(MFC_TIMEOUT);

   localparam logic [1:0] CODE_NONE    = 2'b00;
   localparam logic [1:0] CODE_MEM_ERR = 2'b01;
   localparam logic [1:0] CODE_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STEP     = 2'd1,
      WAIT_MFC = 2'd2,
      FAULT    = 2'd3
   } state_t;

   state_t                  state_r,      state_nx;
   logic [STAGE_W-1:0]      stage_r,      stage_nx;
   logic [NUM_STAGES-1:0]   onehot_r,     onehot_nx;
   logic [7:0]              wait_cnt_r,   wait_nx;
   logic                    done_r,       done_nx;
   logic                    fault_r,      fault_nx;
   logic [1:0]              code_r,       code_nx;
   logic [31:0]             instr_cnt_r,  instr_nx;
   logic [31:0]             cycle_cnt_r,  cycle_nx;

   logic                    waiting_s;    // stage is held for MEM_MFC this cycle
   logic                    mfc_ok_s;     // MFC condition satisfied for advancing
   logic                    step_ok_s;    // advance permitted by the step control
   logic                    adv_s;        // advance the stage on this edge
   logic                    fault_go_s;   // enter FAULT on this edge
   logic [1:0]              fault_code_s; // code latched when entering FAULT

`ifdef STAGE_SINGLE_STEP_EN
   logic                    step_d_r;
   logic                    mfc_seen_r,   mfc_seen_nx;
`endif

   // Decode the wait condition and the advance qualifiers from registered state.
   always_comb begin
      waiting_s = 1'b0;
      if (state_r == WAIT_MFC) begin
         waiting_s = 1'b1;
      end else if (state_r == STEP) begin
         waiting_s = (stage_r == FETCH_C) || ((stage_r == MEM_C) && Mem_Request);
      end else begin
         waiting_s = 1'b0;
      end
`ifdef STAGE_SINGLE_STEP_EN
      // An MFC seen earlier in this stage still counts when the Step rise arrives.
      mfc_ok_s  = MEM_MFC | mfc_seen_r;
      step_ok_s = Step & ~step_d_r;
`else
      mfc_ok_s  = MEM_MFC;
      step_ok_s = 1'b1;
`endif
   end

   // Compute the next state, stage, counters and fault status.
   always_comb begin
      state_nx     = state_r;
      stage_nx     = stage_r;
      wait_nx      = wait_cnt_r;
      done_nx      = 1'b0;
      fault_nx     = fault_r;
      code_nx      = code_r;
      instr_nx     = instr_cnt_r;
      cycle_nx     = cycle_cnt_r;
      adv_s        = 1'b0;
      fault_go_s   = 1'b0;
      fault_code_s = CODE_NONE;
      onehot_nx    = {NUM_STAGES{1'b0}};

      if (Run && (state_r != FAULT)) begin
         cycle_nx = cycle_cnt_r + 32'd1;
      end else begin
         cycle_nx = cycle_cnt_r;
      end

      if (Run) begin
         case (state_r)
            IDLE: begin
               state_nx = STEP;
               stage_nx = FIRST_C;
            end
            STEP, WAIT_MFC: begin
               if (waiting_s) begin
                  // The first wait cycle in STEP already counts toward the timeout.
                  if (MEM_ERROR) begin
                     fault_go_s   = 1'b1;
                     fault_code_s = CODE_MEM_ERR;
                  end else if (mfc_ok_s && step_ok_s) begin
                     adv_s = 1'b1;
                  end else if ((wait_cnt_r + 8'd1) >= TIMEOUT_C) begin
                     fault_go_s   = 1'b1;
                     fault_code_s = CODE_TIMEOUT;
                  end else begin
                     state_nx = WAIT_MFC;
                     wait_nx  = wait_cnt_r + 8'd1;
                  end
               end else if (step_ok_s) begin
                  adv_s = 1'b1;
               end else begin
                  adv_s = 1'b0;
               end
            end
            FAULT: begin
               state_nx = FAULT;
            end
            default: begin
               state_nx = IDLE;
               stage_nx = ZERO_C;
               wait_nx  = 8'd0;
            end
         endcase
      end else begin
         state_nx = state_r;
      end

      if (adv_s) begin
         state_nx = STEP;
         wait_nx  = 8'd0;
         if (stage_r == LAST_C) begin
            stage_nx = FIRST_C;
            done_nx  = 1'b1;
            instr_nx = instr_cnt_r + 32'd1;
         end else begin
            stage_nx = stage_r + FIRST_C;
         end
      end else if (fault_go_s) begin
         state_nx = FAULT;
         stage_nx = ZERO_C;
         wait_nx  = 8'd0;
         fault_nx = 1'b1;
         code_nx  = fault_code_s;
      end else begin
         done_nx = 1'b0;
      end

      for (int i = 0; i < NUM_STAGES; i++) begin
         if (stage_nx == STAGE_W'(i + 1)) begin
            onehot_nx[i] = 1'b1;
         end else begin
            onehot_nx[i] = 1'b0;
         end
      end

`ifdef STAGE_SINGLE_STEP_EN
      if (!Run) begin
         mfc_seen_nx = mfc_seen_r;
      end else if (adv_s || fault_go_s) begin
         mfc_seen_nx = 1'b0;
      end else if (waiting_s && MEM_MFC) begin
         mfc_seen_nx = 1'b1;
      end else begin
         mfc_seen_nx = mfc_seen_r;
      end
`endif
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r     <= IDLE;
         stage_r     <= ZERO_C;
         onehot_r    <= {NUM_STAGES{1'b0}};
         wait_cnt_r  <= 8'd0;
         done_r      <= 1'b0;
         fault_r     <= 1'b0;
         code_r      <= CODE_NONE;
         instr_cnt_r <= 32'd0;
         cycle_cnt_r <= 32'd0;
      end else begin
         state_r     <= state_nx;
         stage_r     <= stage_nx;
         onehot_r    <= onehot_nx;
         wait_cnt_r  <= wait_nx;
         done_r      <= done_nx;
         fault_r     <= fault_nx;
         code_r      <= code_nx;
         instr_cnt_r <= instr_nx;
         cycle_cnt_r <= cycle_nx;
      end
   end

`ifdef STAGE_SINGLE_STEP_EN
   // Step edge detector and the latched MFC flag; both freeze while Run is low.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         step_d_r   <= 1'b0;
         mfc_seen_r <= 1'b0;
      end else if (Run) begin
         step_d_r   <= Step;
         mfc_seen_r <= mfc_seen_nx;
      end else begin
         step_d_r   <= step_d_r;
         mfc_seen_r <= mfc_seen_r;
      end
   end
`endif

   assign Stage        = stage_r;
   assign Stage_OneHot = onehot_r;
   assign Mem_Wait     = waiting_s;
   assign Instr_Done   = done_r;
   assign Fault        = fault_r;
   assign Fault_Code   = code_r;
   assign Instr_Count  = instr_cnt_r;
   assign Cycle_Count  = cycle_cnt_r;

endmodule

// File: tb/tb_multicycle_stage_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for multicycle_stage_sequencer.
// A behavioural reference model tracks the instruction position, the wait
// length, the fault and the counters. Every output is compared against the
// model on every cycle. A second instance with NUM_STAGES=3 covers the short
// sequence and the wrap of the instruction counter.
// -----------------------------------------------------------------------------
module tb_multicycle_stage_sequencer;

   localparam int NS    = 5;
   localparam int FETCH = 1;
   localparam int MEMS  = 4;
   localparam int TO    = 15;

   logic Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic        Reset, Run, Mem_Request, MEM_MFC, MEM_ERROR;
   logic [3:0]  Stage;
   logic [4:0]  Stage_OneHot;
   logic        Mem_Wait, Instr_Done, Fault;
   logic [1:0]  Fault_Code;
   logic [31:0] Instr_Count, Cycle_Count;

   logic        Reset3, Run3;
   logic [3:0]  Stage3;
   logic [2:0]  Stage_OneHot3;
   logic        Mem_Wait3, Instr_Done3, Fault3;
   logic [1:0]  Fault_Code3;
   logic [31:0] Instr_Count3, Cycle_Count3;

   multicycle_stage_sequencer #(
      .NUM_STAGES(NS), .FETCH_STAGE(FETCH), .MEM_STAGE(MEMS),
      .MFC_TIMEOUT(TO), .STAGE_W(4)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Run(Run), .Mem_Request(Mem_Request),
      .MEM_MFC(MEM_MFC), .MEM_ERROR(MEM_ERROR), .Stage(Stage),
      .Stage_OneHot(Stage_OneHot), .Mem_Wait(Mem_Wait), .Instr_Done(Instr_Done),
      .Fault(Fault), .Fault_Code(Fault_Code), .Instr_Count(Instr_Count),
      .Cycle_Count(Cycle_Count)
   );

   multicycle_stage_sequencer #(
      .NUM_STAGES(3), .FETCH_STAGE(1), .MEM_STAGE(3),
      .MFC_TIMEOUT(TO), .STAGE_W(4)
   ) dut3 (
      .Clock(Clock), .Reset(Reset3), .Run(Run3), .Mem_Request(1'b0),
      .MEM_MFC(1'b1), .MEM_ERROR(1'b0), .Stage(Stage3),
      .Stage_OneHot(Stage_OneHot3), .Mem_Wait(Mem_Wait3), .Instr_Done(Instr_Done3),
      .Fault(Fault3), .Fault_Code(Fault_Code3), .Instr_Count(Instr_Count3),
      .Cycle_Count(Cycle_Count3)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: position within the instruction and fault bookkeeping.
   bit        m_active;
   bit        m_fault;
   int        m_stage;
   int        m_wait;      // wait cycles spent in the current stage
   bit [1:0]  m_code;
   bit        m_done;
   bit [31:0] m_instr;
   bit [31:0] m_cycle;

   logic rr, rn, rq, mf, er;
   int   mode;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit must_wait(input logic req);
      return (m_wait > 0) || (m_stage == FETCH) || ((m_stage == MEMS) && req);
   endfunction

   task automatic m_reset();
      m_active = 1'b0; m_fault = 1'b0; m_stage = 0; m_wait = 0;
      m_code = 2'b00; m_done = 1'b0; m_instr = 32'd0; m_cycle = 32'd0;
   endtask

   task automatic m_advance();
      m_wait = 0;
      if (m_stage == NS) begin
         m_stage = 1;
         m_done  = 1'b1;
         m_instr = m_instr + 32'd1;
      end else begin
         m_stage = m_stage + 1;
      end
   endtask

   task automatic m_go_fault(input bit [1:0] code);
      m_fault = 1'b1; m_active = 1'b0; m_stage = 0; m_wait = 0; m_code = code;
   endtask

   task automatic m_edge(input logic r, input logic run, input logic req,
                         input logic mfc, input logic err);
      m_done = 1'b0;
      if (r) begin
         m_reset();
      end else if (run && !m_fault) begin
         m_cycle = m_cycle + 32'd1;
         if (!m_active) begin
            m_active = 1'b1;
            m_stage  = 1;
         end else if (must_wait(req)) begin
            if (err)                    m_go_fault(2'b01);
            else if (mfc)               m_advance();
            else if (m_wait + 1 >= TO)  m_go_fault(2'b10);
            else                        m_wait = m_wait + 1;
         end else begin
            m_advance();
         end
      end
   endtask

   task automatic check_all();
      logic [31:0] oh;
      logic        mw;
      oh = (m_stage == 0) ? 32'd0 : (32'd1 << (m_stage - 1));
      mw = m_active && !m_fault && must_wait(Mem_Request);
      chk("stage",       32'(Stage),        32'(m_stage));
      chk("onehot",      32'(Stage_OneHot), oh);
      chk("mem_wait",    32'(Mem_Wait),     32'(mw));
      chk("instr_done",  32'(Instr_Done),   32'(m_done));
      chk("fault",       32'(Fault),        32'(m_fault));
      chk("fault_code",  32'(Fault_Code),   32'(m_code));
      chk("instr_count", Instr_Count,       m_instr);
      chk("cycle_count", Cycle_Count,       m_cycle);
   endtask

   // One clock cycle: apply inputs after the falling edge, check, clock, update model.
   task automatic cyc(input logic r, input logic run, input logic req,
                      input logic mfc, input logic err);
      Reset = r; Run = run; Mem_Request = req; MEM_MFC = mfc; MEM_ERROR = err;
      #1;
      check_all();
      @(posedge Clock);
      m_edge(r, run, req, mfc, err);
      @(negedge Clock);
   endtask

   task automatic run_to_stage(input int s, input logic req);
      int guard = 0;
      while ((m_stage != s) && (guard < 20)) begin
         cyc(1'b0, 1'b1, req, 1'b1, 1'b0);
         guard++;
      end
      chk("reach_stage", 32'(Stage), 32'(s));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1; Run = 1'b0; Mem_Request = 1'b0; MEM_MFC = 1'b0; MEM_ERROR = 1'b0;
      Reset3 = 1'b1; Run3 = 1'b0;
      m_reset();
      @(negedge Clock);

      // Free running with MFC always present.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (21) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t1_instr", Instr_Count, 32'd4);
      chk("t1_cycle", Cycle_Count, 32'd21);

      // Memory stage waits three cycles for MFC.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_to_stage(4, 1'b1);
      repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t2_stage5", 32'(Stage), 32'd5);

      // Fetch stage timeout.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (14) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_no_fault_yet", 32'(Fault), 32'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_fault", 32'(Fault), 32'd1);
      chk("t3_code", 32'(Fault_Code), 32'd2);
      for (int i = 0; i < 5; i++)
         cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t3_reset_fault", 32'(Fault), 32'd0);
      chk("t3_reset_code", 32'(Fault_Code), 32'd0);

      // MEM_ERROR wins over MFC, first on the entry cycle, then mid-wait.
      run_to_stage(4, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("t4_code", 32'(Fault_Code), 32'd1);
      chk("t4_stage", 32'(Stage), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_to_stage(4, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("t4b_code", 32'(Fault_Code), 32'd1);

      // Run dropped mid-wait; then Reset in stage 3.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (6)  cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4)  cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t5_held", 32'(Fault), 32'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t5_timeout", 32'(Fault_Code), 32'd2);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_to_stage(3, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t5_reset_stage", 32'(Stage), 32'd0);

      // Random traffic against the model.
      mode = 0;
      for (int i = 0; i < 500; i++) begin
         if ((i % 40) == 0) mode = $urandom_range(0, 1);
         rr = ($urandom_range(0, 63) == 0) || (m_fault && ($urandom_range(0, 3) == 0));
         rn = ($urandom_range(0, 7) != 0);
         rq = 1'($urandom_range(0, 1));
         mf = (mode == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
         er = ($urandom_range(0, 40) == 0);
         cyc(rr, rn, rq, mf, er);
      end

      // Three-stage instance and counter wrap.
      chk("t6_reset_stage", 32'(Stage3), 32'd0);
      Reset3 = 1'b0; Run3 = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge Clock); @(negedge Clock);
         chk("t6_stage", 32'(Stage3), 32'((k - 1) % 3 + 1));
      end
      chk("t6_done", 32'(Instr_Done3), 32'd1);
      chk("t6_instr", Instr_Count3, 32'd1);
      Run3 = 1'b0;
      force dut3.instr_cnt_r = 32'hFFFF_FFFF;
      @(posedge Clock); @(negedge Clock);
      release dut3.instr_cnt_r;
      #1;
      chk("t6_forced", Instr_Count3, 32'hFFFF_FFFF);
      Run3 = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         @(posedge Clock); @(negedge Clock);
         chk("t6_stage_b", 32'(Stage3), 32'((k - 1) % 3 + 1));
      end
      chk("t6_wrap", Instr_Count3, 32'd0);
      chk("t6_wrap_done", 32'(Instr_Done3), 32'd1);
      chk("t6_onehot", 32'(Stage_OneHot3), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
